// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the IF/MEM memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // dm_ctrl word-access code; fetches always use it
  localparam logic [2:0] DM_WORD = 3'b000;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - single-ported memory request/ack bus
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_ctrl;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - data-run counter and fetch/data priority select
module arb_starve_cnt #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_en_i,
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic grant_inst_o,
  output logic grant_data_o
);

  localparam int CNT_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             starved;

  // Data normally wins; a fetch that has watched MAX_DATA_RUN data grants goes next
  always_comb begin
    starved      = (run_cnt_q == RUN_MAX);
    grant_inst_o = grant_en_i & inst_req_i & (~data_req_i | starved);
    grant_data_o = grant_en_i & data_req_i & ~grant_inst_o;
    run_cnt_d    = run_cnt_q;
    if (grant_inst_o) begin
      run_cnt_d = '0;
    end else if (grant_data_o) begin
      if (!inst_req_i) begin
        run_cnt_d = '0;
      end else if (!starved) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ready,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [2:0]          data_ctrl,
  output logic                data_ready,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                if_stall,
  output logic                mem_stall,
  mem_port_arbiter_if.master  mem,
  output logic                err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_ctrl_q, mem_ctrl_d;
  logic              inst_ready_q, inst_ready_d;
  logic              data_ready_q, data_ready_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              err_timeout_q, err_timeout_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              grant_inst, grant_data;

  arb_starve_cnt #(.MAX_DATA_RUN(MAX_DATA_RUN)) u_starve (
    .clk          (clk),
    .reset        (reset),
    .grant_en_i   (state_q == ST_IDLE),
    .inst_req_i   (inst_req),
    .data_req_i   (data_req),
    .grant_inst_o (grant_inst),
    .grant_data_o (grant_data)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_ctrl_d    = mem_ctrl_q;
    inst_rdata_d  = inst_rdata_q;
    data_rdata_d  = data_rdata_q;
    tmo_cnt_d     = tmo_cnt_q;
    inst_ready_d  = 1'b0;
    data_ready_d  = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        if (grant_inst) begin
          state_d     = ST_BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = inst_addr;
          mem_wdata_d = '0;
          mem_ctrl_d  = DM_WORD;
        end else if (grant_data) begin
          state_d     = ST_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = data_we;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          mem_ctrl_d  = data_ctrl;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // An ack arriving on the final allowed cycle still completes normally
        if (mem.mem_ack) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (state_q == ST_BUSY_I) begin
            inst_ready_d = 1'b1;
            inst_rdata_d = mem.mem_rdata;
          end else begin
            data_ready_d = 1'b1;
            if (!mem_we_q) data_rdata_d = mem.mem_rdata;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d       = ST_RESP;
          mem_req_d     = 1'b0;
          err_timeout_d = 1'b1;
          if (state_q == ST_BUSY_I) begin
            inst_ready_d = 1'b1;
            inst_rdata_d = '0;
          end else begin
            data_ready_d = 1'b1;
            data_rdata_d = '0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_ctrl_q    <= '0;
      inst_ready_q  <= 1'b0;
      data_ready_q  <= 1'b0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
      err_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_ctrl_q    <= mem_ctrl_d;
      inst_ready_q  <= inst_ready_d;
      data_ready_q  <= data_ready_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rdata_q  <= data_rdata_d;
      err_timeout_q <= err_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_ctrl  = mem_ctrl_q;
  assign inst_ready    = inst_ready_q;
  assign data_ready    = data_ready_q;
  assign inst_rdata    = inst_rdata_q;
  assign data_rdata    = data_rdata_q;
  assign err_timeout   = err_timeout_q;
  assign if_stall      = inst_req & ~inst_ready_q;
  assign mem_stall     = data_req & ~data_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MAXRUN = 4;
  localparam int TMO    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_req, data_req, data_we;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] data_wdata;
  logic [2:0]    data_ctrl;
  logic          inst_ready, data_ready, if_stall, mem_stall, err_timeout;
  logic [DW-1:0] inst_rdata, data_rdata;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAXRUN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ctrl(data_ctrl), .data_ready(data_ready), .data_rdata(data_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall), .mem(mif), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    bit          tmo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  bit          manual = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  // Memory responder and grant model: decides each access's outcome and queues the expected reply
  initial begin : responder
    int          ack_in = -1;
    bit          active = 1'b0;
    bit          stable_ok;
    int          req_len = 0, exp_len = 0, streak = 0;
    bit          req_prev = 1'b0, snap_ireq = 1'b0, snap_dreq = 1'b0, want_inst;
    logic [31:0] lat_addr, lat_wdata, ack_val = 0, exp_data_rd = 0;
    logic        lat_we;
    logic [2:0]  lat_ctrl;
    exp_t        e;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = $urandom();
      end
      if (reset || manual) begin
        ack_in = -1;
        active = 1'b0;
        streak = 0;
        exp_data_rd = 0;
      end else begin
        if (mif.mem_req && !req_prev) begin
          chk("grant_has_request", {31'd0, snap_ireq | snap_dreq}, 32'd1);
          want_inst = snap_ireq && (!snap_dreq || streak == MAXRUN);
          lat_we    = want_inst ? 1'b0 : data_we;
          lat_addr  = want_inst ? inst_addr : data_addr;
          lat_ctrl  = want_inst ? 3'd0 : data_ctrl;
          lat_wdata = mif.mem_wdata;
          chk("grant_addr", mif.mem_addr, lat_addr);
          chk("grant_we", {31'd0, mif.mem_we}, {31'd0, lat_we});
          chk("grant_ctrl", {29'd0, mif.mem_ctrl}, {29'd0, lat_ctrl});
          if (!want_inst) chk("grant_wdata", mif.mem_wdata, data_wdata);
          if (want_inst) streak = 0;
          else if (snap_ireq) streak = (streak < MAXRUN) ? streak + 1 : MAXRUN;
          else streak = 0;
          e.is_data = !want_inst;
          if ($urandom_range(0, 7) == 0) begin
            ack_in  = -1;
            exp_len = TMO;
            e.tmo   = 1'b1;
            e.rdata = 0;
            e.cyc   = cyc + TMO;
            if (!want_inst) exp_data_rd = 0;
          end else begin
            ack_in  = $urandom_range(0, 4);
            exp_len = ack_in + 1;
            e.tmo   = 1'b0;
            e.cyc   = cyc + 1 + ack_in;
            ack_val = mem_read(lat_addr);
            if (want_inst) begin
              e.rdata = ack_val;
            end else if (lat_we) begin
              ref_mem[lat_addr] = data_wdata;
              e.rdata = exp_data_rd;
            end else begin
              exp_data_rd = ack_val;
              e.rdata = ack_val;
            end
          end
          sb_q.push_back(e);
          active    = 1'b1;
          stable_ok = 1'b1;
          req_len   = 0;
        end else if (mif.mem_req && active) begin
          if (mif.mem_addr !== lat_addr || mif.mem_we !== lat_we ||
              mif.mem_ctrl !== lat_ctrl || mif.mem_wdata !== lat_wdata) stable_ok = 1'b0;
        end
        if (mif.mem_req && active) req_len++;
        if (!mif.mem_req && req_prev && active) begin
          chk("mem_req_length", req_len, exp_len);
          chk("mem_fields_stable", {31'd0, stable_ok}, 32'd1);
          active = 1'b0;
        end
        if (ack_in == 0) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = ack_val;
          ack_in = -1;
        end else if (ack_in > 0) begin
          ack_in--;
        end else if (!mif.mem_req && $urandom_range(0, 9) == 0) begin
          mif.mem_ack = 1'b1;
        end
      end
      req_prev  = mif.mem_req;
      snap_ireq = inst_req;
      snap_dreq = data_req;
    end
  end

  // Response monitor: pops the scoreboard whenever a ready pulse appears
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      chk("if_stall", {31'd0, if_stall}, {31'd0, inst_req & ~inst_ready});
      chk("mem_stall", {31'd0, mem_stall}, {31'd0, data_req & ~data_ready});
      if (inst_ready || data_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ready", {30'd0, inst_ready, data_ready}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("ready_target", {30'd0, inst_ready, data_ready}, e.is_data ? 32'd1 : 32'd2);
          chk("ready_rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
          chk("err_timeout", {31'd0, err_timeout}, {31'd0, e.tmo});
          chk("ready_cycle", cyc, e.cyc);
        end
      end else if (err_timeout) begin
        chk("timeout_without_ready", 32'd1, 32'd0);
      end
    end
  end

  task automatic wait_ready(input bit is_d, input string nm);
    int   t = 0;
    logic r;
    do begin
      @(negedge clk);
      t++;
      r = is_d ? data_ready : inst_ready;
    end while (!r && t < 300);
    if (!r) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic run_inst(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
      inst_req  = 1'b1;
      inst_addr = 32'h1000_0000 | ($urandom_range(0, 255) << 2);
      wait_ready(1'b0, "inst_ready_bound");
      @(posedge clk);
      #1 inst_req = 1'b0;
    end
  endtask

  task automatic run_data(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
      data_req   = 1'b1;
      data_we    = ($urandom_range(0, 2) == 0);
      data_addr  = 32'h100 + ($urandom_range(0, 7) << 2);
      data_wdata = $urandom();
      data_ctrl  = 3'($urandom_range(0, 4));
      wait_ready(1'b1, "data_ready_bound");
      @(posedge clk);
      #1 data_req = 1'b0;
    end
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, "_mem_req"}, {31'd0, mif.mem_req}, 32'd0);
    chk({nm, "_mem_we"}, {31'd0, mif.mem_we}, 32'd0);
    chk({nm, "_mem_addr"}, mif.mem_addr, 32'd0);
    chk({nm, "_mem_wdata"}, mif.mem_wdata, 32'd0);
    chk({nm, "_mem_ctrl"}, {29'd0, mif.mem_ctrl}, 32'd0);
    chk({nm, "_readies"}, {30'd0, inst_ready, data_ready}, 32'd0);
    chk({nm, "_inst_rdata"}, inst_rdata, 32'd0);
    chk({nm, "_data_rdata"}, data_rdata, 32'd0);
    chk({nm, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int t;
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_ctrl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    fork
      run_inst(40, 6);
      run_data(40, 6);
    join
    fork
      run_inst(15, 0);
      run_data(60, 0);
    join
    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    @(posedge clk);
    #1;
    manual = 1'b1;
    mif.mem_ack = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200; data_ctrl = 3'd0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mif.mem_req && t < 10);
    chk("reset_test_grant", {31'd0, mif.mem_req}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    data_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_cleared("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    mif.mem_ack = 1'b1;
    mif.mem_rdata = 32'hBAD0_0001;
    @(posedge clk);
    #1 mif.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_cleared("post_reset");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
